fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage with PC register and a one-entry skid buffer.
- Sits directly upstream of the decode/control logic: owns the PC, issues requests to instruction memory, and holds the IF/ID instruction register.
- Its 4-bit opcode output feeds the control unit's opcode input.
- Accepts PC redirects from branch/jump resolution and stalls from the hazard logic.

Parameters:
PC_WIDTH, 8, PC and instruction-memory word-address width
INSTR_WIDTH, 16, instruction width; opcode is instr[INSTR_WIDTH-1 -: 4]
RESET_PC, 0, PC value after reset
BUBBLE, 16'hF000, instruction injected when there is no valid instruction (opcode 4'b1111 decodes to all control signals 0)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_req  out  1  fetch request; level, held until imem_valid
imem_addr  out  PC_WIDTH  word address; stable while imem_req=1
imem_rdata  in  INSTR_WIDTH  fetched instruction, qualified by imem_valid
imem_valid  in  1  response strobe, 1 or more cycles after request; ignored when imem_req=0
stall  in  1  decode cannot accept; hold IF/ID outputs
redirect  in  1  taken branch/jump this cycle
redirect_pc  in  PC_WIDTH  new fetch address
instr_out  out  INSTR_WIDTH  IF/ID instruction register
opcode  out  4  instr_out top 4 bits, combinational from the register
pc_out  out  PC_WIDTH  address of instr_out
valid_out  out  1  instr_out holds a real instruction

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC, state=FETCH, instr_out=BUBBLE, opcode=4'hF, pc_out=0, valid_out=0.
  - Skid buffer: empty, contents BUBBLE.
  - imem_req=0 while rst_n=0.
  - First request is issued in the first cycle after release.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - FULL: skid buffer occupied, imem_req=0.
- Accept rule: IF/ID can load when valid_out=0 or stall=0.
- FETCH with imem_valid=1 and accept:
  - instr_out<=imem_rdata, pc_out<=pc, valid_out<=1.
  - pc<=pc+1, wrapping modulo 2^PC_WIDTH (8'hFF -> 8'h00).
  - Back-to-back responses give one instruction per cycle.
- FETCH with imem_valid=1 and no accept:
  - skid<=imem_rdata, skid_pc<=pc, pc<=pc+1, go to FULL.
- FULL with stall=0: instr_out<=skid, pc_out<=skid_pc, valid_out<=1, go to FETCH. The request resumes the same cycle the state returns.
- FULL with stall=1: hold everything.
- No new instruction but stall=0: valid_out<=0, instr_out<=BUBBLE (consumed).
- stall=1 with valid_out=1: instr_out, pc_out and valid_out remain unchanged.
- Redirect has highest priority, regardless of stall or state:
  - pc<=redirect_pc, valid_out<=0, instr_out<=BUBBLE.
  - Skid emptied, state<=FETCH.
  - Any imem_valid in the same cycle is discarded.
  - imem_req may drop/change address; instruction memory treats an address change as cancel.
  - Next cycle: imem_addr=redirect_pc.
- Redirect to the current pc value is still a flush.
- Async reset mid-request: all state returns to reset values immediately, and any later imem_valid is ignored until re-requested.
- Outputs are registered, except opcode, which is a direct slice of instr_out.
- Latency: request to instr_out visible = memory latency + 1 cycle.

Test Plan:
- Reset release, 1-cycle memory returning 16'h1234, 16'h9567, 16'hB0A0 -> pc_out 0,1,2 with valid_out=1 on consecutive cycles; opcode 1, 9, B; before the first response, opcode=F and valid_out=0.
- stall=1 for 3 cycles while valid_out=1 and a response 16'h2ABC arrives -> instr_out held; state FULL, imem_req=0; on stall=0, instr_out=16'h2ABC with the next sequential pc_out and no instruction lost.
- redirect=1, redirect_pc=8'h40, same cycle as imem_valid -> response dropped; valid_out=0, opcode=F; next cycle imem_addr=8'h40.
- pc=8'hFF fetch -> next imem_addr=8'h00.
- Memory latency 3 cycles -> imem_addr stable and imem_req high for 3 cycles; exactly one instruction captured.
- rst_n low mid-request with skid full -> immediate valid_out=0, instr_out=16'hF000, pc=0; a stale imem_valid during reset is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory requests and
// holds the IF/ID register, with a one-entry skid buffer absorbing a response during stall.
//
// state | meaning
// FETCH | request outstanding at imem_addr = pc
// FULL  | skid buffer holds an instruction decode has not taken yet; no request
module fetch_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] BUBBLE      = 16'hF000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [3:0]             opcode,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid_out
);

    typedef enum logic {
        FETCH = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t                 state, state_next;
    logic [PC_WIDTH-1:0]    pc, pc_next;
    logic [INSTR_WIDTH-1:0] skid, skid_next;
    logic [PC_WIDTH-1:0]    skid_pc, skid_pc_next;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic [PC_WIDTH-1:0]    pc_out_next;
    logic                   valid_next;
    logic                   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            skid      <= BUBBLE;
            skid_pc   <= '0;
            instr_out <= BUBBLE;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            skid      <= skid_next;
            skid_pc   <= skid_pc_next;
            instr_out <= instr_next;
            pc_out    <= pc_out_next;
            valid_out <= valid_next;
        end
    end

    // IF/ID may load when it is empty or decode is taking its current contents.
    assign accept = !valid_out || !stall;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        skid_next    = skid;
        skid_pc_next = skid_pc;
        instr_next   = instr_out;
        pc_out_next  = pc_out;
        valid_next   = valid_out;

        if (redirect) begin
            // Flush wins over everything, including a response arriving this cycle.
            pc_next      = redirect_pc;
            valid_next   = 1'b0;
            instr_next   = BUBBLE;
            skid_next    = BUBBLE;
            skid_pc_next = '0;
            state_next   = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_valid) begin
                        pc_next = pc + PC_ONE;
                        if (accept) begin
                            instr_next  = imem_rdata;
                            pc_out_next = pc;
                            valid_next  = 1'b1;
                        end else begin
                            skid_next    = imem_rdata;
                            skid_pc_next = pc;
                            state_next   = FULL;
                        end
                    end else if (accept) begin
                        valid_next = 1'b0;
                        instr_next = BUBBLE;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr_next   = skid;
                        pc_out_next  = skid_pc;
                        valid_next   = 1'b1;
                        skid_next    = BUBBLE;
                        state_next   = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // Gated by rst_n so no request is seen while reset is held.
    assign imem_req  = rst_n && (state == FETCH);
    assign imem_addr = pc;
    assign opcode    = instr_out[INSTR_WIDTH-1 -: 4];

endmodule
